// File: rtl/ledger_pkg.sv
// Shared definitions for the ledger memory handshake: phase codes seen by the
// memory controller, transfer result codes, and the initiator state encoding.
package ledger_pkg;

    localparam logic [2:0] PROC_IDLE   = 3'd0;
    localparam logic [2:0] PROC_LOAD   = 3'd1;
    localparam logic [2:0] PROC_CHECK  = 3'd2;
    localparam logic [2:0] PROC_UPDATE = 3'd3;
    localparam logic [2:0] PROC_COMMIT = 3'd4;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_FUNDS    = 2'b01,
        ERR_OVERFLOW = 2'b10,
        ERR_INVALID  = 2'b11
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQUEST   = 3'd1,
        ST_LOAD_WAIT = 3'd2,
        ST_CHECK     = 3'd3,
        ST_UPDATE    = 3'd4,
        ST_COMMIT    = 3'd5,
        ST_RESPOND   = 3'd6
    } state_e;

endpackage

// File: rtl/transfer_check.sv
// Pure combinational transfer rule: classifies a request and produces the
// balances to write back (unchanged on any error).
module transfer_check
    import ledger_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] amount,
    input  logic [WIDTH-1:0] sender_balance,
    input  logic [WIDTH-1:0] receiver_balance,
    input  logic             same_account,
    output err_code_e        code,
    output logic [WIDTH-1:0] new_sender_balance,
    output logic [WIDTH-1:0] new_receiver_balance
);

    logic [WIDTH:0] receiver_sum;

    assign receiver_sum = {1'b0, receiver_balance} + {1'b0, amount};

    always_comb begin
        code                 = ERR_OK;
        new_sender_balance   = sender_balance;
        new_receiver_balance = receiver_balance;
        if (amount == '0 || same_account) begin
            code = ERR_INVALID;
        end else if (amount > sender_balance) begin
            code = ERR_FUNDS;
        end else if (receiver_sum[WIDTH]) begin
            code = ERR_OVERFLOW;
        end else begin
            new_sender_balance   = sender_balance - amount;
            new_receiver_balance = receiver_sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/transfer_control.sv
// Initiator of the ledger load/validate/commit handshake. One request in
// flight; every output is a flop or a decode of the state register.
module transfer_control
    import ledger_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = 5,
    parameter int LOAD_WAIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_sender,
    input  logic [ADDR_W-1:0] req_receiver,
    input  logic [WIDTH-1:0]  req_amount,
    input  logic              mem_done,
    input  logic [WIDTH-1:0]  sender_balance,
    input  logic [WIDTH-1:0]  receiver_balance,
    output logic              load_memory,
    output logic [2:0]        process,
    output logic [ADDR_W-1:0] sender_addr,
    output logic [ADDR_W-1:0] receiver_addr,
    output logic [WIDTH-1:0]  new_sender_balance,
    output logic [WIDTH-1:0]  new_receiver_balance,
    output logic              resp_valid,
    output logic              resp_ok,
    output logic [1:0]        resp_error
);

    localparam int CNT_W = $clog2(LOAD_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_WAIT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sender_addr_q, sender_addr_d;
    logic [ADDR_W-1:0] receiver_addr_q, receiver_addr_d;
    logic [WIDTH-1:0]  amount_q, amount_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  sender_bal_q, sender_bal_d;
    logic [WIDTH-1:0]  receiver_bal_q, receiver_bal_d;
    err_code_e         code_q, code_d;
    logic [WIDTH-1:0]  new_sender_q, new_sender_d;
    logic [WIDTH-1:0]  new_receiver_q, new_receiver_d;

    logic [WIDTH-1:0]  chk_sender_bal;
    logic [WIDTH-1:0]  chk_receiver_bal;
    err_code_e         chk_code;
    logic [WIDTH-1:0]  chk_new_sender;
    logic [WIDTH-1:0]  chk_new_receiver;

    // Live memory data is only trusted in CHECK; afterwards the latched copy
    // feeds the rule so UPDATE computes from exactly what was classified.
    assign chk_sender_bal   = (state_q == ST_CHECK) ? sender_balance   : sender_bal_q;
    assign chk_receiver_bal = (state_q == ST_CHECK) ? receiver_balance : receiver_bal_q;

    transfer_check #(
        .WIDTH(WIDTH)
    ) u_check (
        .amount              (amount_q),
        .sender_balance      (chk_sender_bal),
        .receiver_balance    (chk_receiver_bal),
        .same_account        (sender_addr_q == receiver_addr_q),
        .code                (chk_code),
        .new_sender_balance  (chk_new_sender),
        .new_receiver_balance(chk_new_receiver)
    );

    always_comb begin
        state_d         = state_q;
        sender_addr_d   = sender_addr_q;
        receiver_addr_d = receiver_addr_q;
        amount_d        = amount_q;
        cnt_d           = cnt_q;
        sender_bal_d    = sender_bal_q;
        receiver_bal_d  = receiver_bal_q;
        code_d          = code_q;
        new_sender_d    = new_sender_q;
        new_receiver_d  = new_receiver_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    sender_addr_d   = req_sender;
                    receiver_addr_d = req_receiver;
                    amount_d        = req_amount;
                    state_d         = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                cnt_d   = '0;
                state_d = ST_LOAD_WAIT;
            end
            ST_LOAD_WAIT: begin
                // Only cycles with the controller busy count toward the load.
                if (!mem_done) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                sender_bal_d   = sender_balance;
                receiver_bal_d = receiver_balance;
                code_d         = chk_code;
                state_d        = ST_UPDATE;
            end
            ST_UPDATE: begin
                new_sender_d   = chk_new_sender;
                new_receiver_d = chk_new_receiver;
                state_d        = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (mem_done) begin
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            sender_addr_q   <= '0;
            receiver_addr_q <= '0;
            amount_q        <= '0;
            cnt_q           <= '0;
            sender_bal_q    <= '0;
            receiver_bal_q  <= '0;
            code_q          <= ERR_OK;
            new_sender_q    <= '0;
            new_receiver_q  <= '0;
        end else begin
            state_q         <= state_d;
            sender_addr_q   <= sender_addr_d;
            receiver_addr_q <= receiver_addr_d;
            amount_q        <= amount_d;
            cnt_q           <= cnt_d;
            sender_bal_q    <= sender_bal_d;
            receiver_bal_q  <= receiver_bal_d;
            code_q          <= code_d;
            new_sender_q    <= new_sender_d;
            new_receiver_q  <= new_receiver_d;
        end
    end

    always_comb begin
        process = PROC_IDLE;
        case (state_q)
            ST_REQUEST, ST_LOAD_WAIT: process = PROC_LOAD;
            ST_CHECK:                 process = PROC_CHECK;
            ST_UPDATE:                process = PROC_UPDATE;
            ST_COMMIT:                process = PROC_COMMIT;
            default:                  process = PROC_IDLE;
        endcase
    end

    assign req_ready            = (state_q == ST_IDLE);
    assign load_memory          = (state_q == ST_REQUEST);
    assign resp_valid           = (state_q == ST_RESPOND);
    assign resp_ok              = (state_q == ST_RESPOND) && (code_q == ERR_OK);
    assign resp_error           = (state_q == ST_RESPOND) ? code_q : ERR_OK;
    assign sender_addr          = sender_addr_q;
    assign receiver_addr        = receiver_addr_q;
    assign new_sender_balance   = new_sender_q;
    assign new_receiver_balance = new_receiver_q;

endmodule

// File: tb/tb_transfer_control.sv
// Directed bench for transfer_control with a cycle-level memory controller
// model; expectations are queued at issue time and checked by a monitor.
module tb_transfer_control;

    localparam int WIDTH     = 32;
    localparam int ADDR_W    = 5;
    localparam int LOAD_WAIT = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_sender;
    logic [ADDR_W-1:0] req_receiver;
    logic [WIDTH-1:0]  req_amount;
    logic              mem_done;
    logic [WIDTH-1:0]  sender_balance;
    logic [WIDTH-1:0]  receiver_balance;
    logic              load_memory;
    logic [2:0]        process;
    logic [ADDR_W-1:0] sender_addr;
    logic [ADDR_W-1:0] receiver_addr;
    logic [WIDTH-1:0]  new_sender_balance;
    logic [WIDTH-1:0]  new_receiver_balance;
    logic              resp_valid;
    logic              resp_ok;
    logic [1:0]        resp_error;

    transfer_control #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .LOAD_WAIT(LOAD_WAIT)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sender(req_sender), .req_receiver(req_receiver), .req_amount(req_amount),
        .mem_done(mem_done),
        .sender_balance(sender_balance), .receiver_balance(receiver_balance),
        .load_memory(load_memory), .process(process),
        .sender_addr(sender_addr), .receiver_addr(receiver_addr),
        .new_sender_balance(new_sender_balance), .new_receiver_balance(new_receiver_balance),
        .resp_valid(resp_valid), .resp_ok(resp_ok), .resp_error(resp_error)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory controller model ----------------
    int          m_delay = 0;
    int          m_phase = 0;   // 0 idle, 1 delayed start, 2 loading, 3 writing
    int          m_cnt   = 0;
    logic [WIDTH-1:0] m_sbal = '0;
    logic [WIDTH-1:0] m_rbal = '0;

    always @(posedge clock) begin
        if (reset) begin
            mem_done <= 1'b1;
            m_phase  <= 0;
            m_cnt    <= 0;
        end else begin
            case (m_phase)
                0: begin
                    if (load_memory) begin
                        if (m_delay == 0) begin
                            mem_done <= 1'b0; m_phase <= 2; m_cnt <= LOAD_WAIT - 1;
                        end else begin
                            m_phase <= 1; m_cnt <= m_delay - 1;
                        end
                    end else if (process == 3'd3) begin
                        mem_done <= 1'b0; m_phase <= 3; m_cnt <= 8;
                    end
                end
                1: begin
                    if (m_cnt == 0) begin
                        mem_done <= 1'b0; m_phase <= 2; m_cnt <= LOAD_WAIT - 1;
                    end else m_cnt <= m_cnt - 1;
                end
                default: begin
                    if (m_cnt == 0) begin
                        mem_done <= 1'b1; m_phase <= 0;
                    end else m_cnt <= m_cnt - 1;
                end
            endcase
        end
    end

    // Balances are garbage until the load has actually finished.
    assign sender_balance   = (m_phase == 0 && mem_done) ? m_sbal : 32'hDEAD_BEEF;
    assign receiver_balance = (m_phase == 0 && mem_done) ? m_rbal : 32'hDEAD_BEEF;

    // ---------------- scoreboard ----------------
    typedef struct {
        int               cycle;
        logic             ok;
        logic [1:0]       err;
        logic [WIDTH-1:0] ns;
        logic [WIDTH-1:0] nr;
        logic [ADDR_W-1:0] sa;
        logic [ADDR_W-1:0] ra;
    } resp_t;

    int    load_q[$];
    int    check_q[$];
    int    commit_q[$];
    resp_t resp_q[$];
    logic [2:0] prev_proc = 3'd0;

    task automatic push_exp(input int a, input int d, input logic [1:0] err,
                            input logic [WIDTH-1:0] ns, input logic [WIDTH-1:0] nr,
                            input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ra);
        resp_t r;
        load_q.push_back(a + 1);
        check_q.push_back(a + 10 + d);
        commit_q.push_back(a + 12 + d);
        r.cycle = a + 22 + d; r.ok = (err == 2'b00); r.err = err;
        r.ns = ns; r.nr = nr; r.sa = sa; r.ra = ra;
        resp_q.push_back(r);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (load_memory) begin
                if (load_q.size() == 0) check("spurious_load", 1, 0);
                else check("load_cycle", cyc, load_q.pop_front());
            end
            if (process == 3'd2 && prev_proc != 3'd2) begin
                if (check_q.size() == 0) check("spurious_check", 1, 0);
                else check("check_cycle", cyc, check_q.pop_front());
            end
            if (process == 3'd4 && prev_proc != 3'd4) begin
                if (commit_q.size() == 0) check("spurious_commit", 1, 0);
                else check("commit_cycle", cyc, commit_q.pop_front());
            end
            if (resp_valid) begin
                if (resp_q.size() == 0) check("spurious_resp", 1, 0);
                else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    check("resp_cycle", cyc, r.cycle);
                    check("resp_ok", resp_ok, r.ok);
                    check("resp_error", resp_error, r.err);
                    check("new_sender", new_sender_balance, r.ns);
                    check("new_receiver", new_receiver_balance, r.nr);
                    check("sender_addr", sender_addr, r.sa);
                    check("receiver_addr", receiver_addr, r.ra);
                end
            end
        end
        prev_proc = reset ? 3'd0 : process;
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] r,
                         input logic [WIDTH-1:0] amt, output int a);
        int guard;
        @(negedge clock);
        req_sender = s; req_receiver = r; req_amount = amt; req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 100) begin @(negedge clock); guard++; end
        if (!req_ready) check("accept_timeout", 0, 1);
        a = cyc;
    endtask

    task automatic run(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] r,
                       input logic [WIDTH-1:0] amt, input logic [WIDTH-1:0] sb,
                       input logic [WIDTH-1:0] rb, input int d, input logic [1:0] err,
                       input logic [WIDTH-1:0] ns, input logic [WIDTH-1:0] nr);
        int a;
        m_sbal = sb; m_rbal = rb; m_delay = d;
        issue(s, r, amt, a);
        push_exp(a, d, err, ns, nr, s, r);
        @(negedge clock);
        req_valid = 1'b0;
        repeat (26 + d) @(negedge clock);
    endtask

    initial begin
        int a1, a2, guard, ready_hi;
        reset = 1'b1; req_valid = 1'b0;
        req_sender = '0; req_receiver = '0; req_amount = '0;
        repeat (2) @(negedge clock);
        check("rst_ready", req_ready, 1);
        check("rst_process", process, 0);
        check("rst_outputs", {load_memory, resp_valid, resp_ok, resp_error}, 0);
        check("rst_data", {sender_addr, receiver_addr, new_sender_balance, new_receiver_balance}, 0);
        reset = 1'b0;

        run(5'd3,  5'd7,  32'd30,   32'd100,    32'd50,        0, 2'b00, 32'd70,     32'd80);
        run(5'd3,  5'd7,  32'd101,  32'd100,    32'd50,        0, 2'b01, 32'd100,    32'd50);
        run(5'd1,  5'd2,  32'h20,   32'h100,    32'hFFFF_FFF0, 0, 2'b10, 32'h100,    32'hFFFF_FFF0);
        run(5'd1,  5'd2,  32'h20,   32'h20,     32'hFFFF_FFDF, 0, 2'b00, 32'h0,      32'hFFFF_FFFF);
        run(5'd4,  5'd6,  32'd0,    32'd500,    32'd500,       0, 2'b11, 32'd500,    32'd500);
        run(5'd9,  5'd9,  32'd5,    32'd500,    32'd500,       0, 2'b11, 32'd500,    32'd500);

        // req_valid held high across a whole transfer; fields change mid-flight.
        m_sbal = 32'd10; m_rbal = 32'd20; m_delay = 0;
        issue(5'd1, 5'd2, 32'd10, a1);
        push_exp(a1, 0, 2'b00, 32'd0, 32'd30, 5'd1, 5'd2);
        @(negedge clock);
        req_sender = 5'd4; req_receiver = 5'd5; req_amount = 32'd999;
        guard = 0; ready_hi = 0;
        while (!req_ready && guard < 100) begin
            if (cyc == a1 + 22) begin m_sbal = 32'd1000; m_rbal = 32'd0; end
            @(negedge clock); guard++;
        end
        a2 = cyc;
        check("second_accept_cycle", a2, a1 + 23);
        push_exp(a2, 0, 2'b00, 32'd1, 32'd999, 5'd4, 5'd5);
        @(negedge clock);
        req_valid = 1'b0;
        if (req_ready) ready_hi++;
        check("ready_low_after_accept", ready_hi, 0);
        repeat (26) @(negedge clock);

        // Reset during LOAD_WAIT: no response, outputs back to reset values.
        m_sbal = 32'd1; m_rbal = 32'd1; m_delay = 0;
        issue(5'd2, 5'd3, 32'd1, a1);
        load_q.push_back(a1 + 1);
        @(negedge clock);
        req_valid = 1'b0;
        while (cyc < a1 + 5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_ready", req_ready, 1);
        check("midrst_process", process, 0);
        check("midrst_outputs", {load_memory, resp_valid, resp_ok, resp_error}, 0);
        check("midrst_data", {sender_addr, receiver_addr, new_sender_balance, new_receiver_balance}, 0);
        reset = 1'b0;
        repeat (30) @(negedge clock);

        run(5'd9,  5'd10, 32'd7,    32'd7,         32'd8, 0, 2'b00, 32'd0, 32'd15);
        run(5'd11, 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 3, 2'b00, 32'd0, 32'hFFFF_FFFF);

        guard = 0;
        while ((resp_q.size() != 0 || load_q.size() != 0) && guard < 200) begin
            @(negedge clock); guard++;
        end
        check("pending_resp", resp_q.size(), 0);
        check("pending_load", load_q.size(), 0);
        check("pending_commit", commit_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/transfer_control.md
# transfer_control

Initiator side of the ledger memory handshake. Accepts one coin-transfer request at a time and asserts `load_memory` so the memory controller fetches the sender and receiver balances. It validates and computes the new balances, then drives `process` to the commit code so the controller writes them back. It waits for the controller's `done` before reporting the result. It sits between the transaction front-end and `memory_control`, which is the responder.

## Interface
Parameters:
- `WIDTH`, default 32: balance and amount width.
- `ADDR_W`, default 5: account address width.
- `LOAD_WAIT`, default 8: number of cycles `mem_done` must be low before loaded data is valid. Equals the controller's load duration.

Ports:
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_sender`, `req_receiver`  in  ADDR_W  account addresses.
- `req_amount`  in  WIDTH  amount to transfer.
- `mem_done`  in  1  controller idle/finished flag.
- `sender_balance`, `receiver_balance`  in  WIDTH  loaded memory data.
- `load_memory`  out  1  single-cycle load strobe.
- `process`  out  3  phase code; 3'b100 = commit.
- `sender_addr`, `receiver_addr`  out  ADDR_W  latched addresses.
- `new_sender_balance`, `new_receiver_balance`  out  WIDTH  write-back data.
- `resp_valid`  out  1  single-cycle response.
- `resp_ok`  out  1  transfer applied.
- `resp_error`  out  2  error code: 00 ok, 01 insufficient funds, 10 receiver overflow, 11 invalid.

## Operation
- **IDLE** (`process`=0, `req_ready`=1). On `req_valid`, latch sender, receiver and amount, then go to REQUEST.
- **REQUEST** (`process`=1). `load_memory`=1 for exactly this cycle. Clear the wait counter. Go to LOAD_WAIT.
- **LOAD_WAIT** (`process`=1). The counter increments only on cycles where `mem_done`=0. After the LOAD_WAIT-th such cycle, go to CHECK.
- **CHECK** (`process`=2). Classify the request, first match wins:
  - invalid (11) if `req_amount`==0 or sender==receiver;
  - insufficient funds (01) if `amount` > `sender_balance`;
  - receiver overflow (10) if `receiver_balance`+`amount` carries out of WIDTH bits;
  - otherwise ok (00).
  - Register the code.
- **UPDATE** (`process`=3).
  - On ok: `new_sender_balance` = sender − amount and `new_receiver_balance` = receiver + amount, both WIDTH-bit unsigned.
  - On error: both outputs take the loaded values unchanged. The write-back still happens so the controller returns to idle.
- **COMMIT** (`process`=4). Hold until `mem_done`=1, then go to RESPOND. `new_*` and `*_addr` remain stable throughout the write.
- **RESPOND** (`process`=0). Assert `resp_valid` with `resp_ok` = (code==00) and `resp_error` = code. Go to IDLE.
- `new_*` and `*_addr` keep their values until the next UPDATE or acceptance.
- `req_valid` outside IDLE is ignored and not queued.

## Timing
- Reset values:
  - state IDLE; `req_ready`=1; `process`=0;
  - `load_memory`, `resp_valid`, `resp_ok` = 0; `resp_error`=00;
  - addresses, balances and counter = 0.
- Reset mid-transfer: return to IDLE next cycle with no response. `memory_control` shares the same reset, so both ends resynchronise.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Nominal latency with the default controller (8-cycle load, 8-cycle write):
  - acceptance at cycle 0; `load_memory` at cycle 1;
  - LOAD_WAIT cycles 2–9; CHECK at 10; UPDATE at 11;
  - COMMIT from 12 with `mem_done` rising at 21;
  - `resp_valid` at cycle 22.
- If `mem_done` stays high, LOAD_WAIT waits indefinitely. No timeout.
- `mem_done` low on COMMIT entry is the normal case. `mem_done` already high on COMMIT entry exits after one cycle.

## Structure
- Shared package `ledger_pkg` holds:
  - process codes (IDLE 0, LOAD 1, CHECK 2, UPDATE 3, COMMIT 4);
  - error codes;
  - the state encoding.
- One sub-module: `transfer_check`. It is combinational and maps amount and the two balances to an error code plus the two new balances. It is instanced in CHECK/UPDATE and reusable by the bench as a reference model.

## Test plan
- Sender 100, receiver 50, amount 30, with a controller model:
  - `load_memory` pulses at cycle 1;
  - `process`=4 at cycle 12;
  - `new_*` = 70 and 80;
  - `resp_valid` at cycle 22 with ok.
- Amount 101 against sender 100: write-back of 100 and 50 unchanged; `resp_error`=01; `resp_ok`=0.
- Receiver 0xFFFFFFF0, amount 0x20: error 10. Amount 0, or sender==receiver: error 11. Both still commit and respond.
- `req_valid` held high throughout: `req_ready` low from cycle 1 until IDLE. The second request is accepted only at cycle 23.
- `reset` asserted at cycle 5 mid-LOAD_WAIT:
  - all outputs return to reset values next cycle;
  - no `resp_valid`;
  - a fresh request then completes normally.
- Model delays the fall of `mem_done` by 3 cycles: CHECK is delayed by exactly 3 cycles, and balances are sampled correctly.
